ex_stage: RTL and testbench

- Execute stage of the 5-stage pipelined CPU. Sits between the ID/EX register and the memory-access stage.
- Performs ALU operations, computes the branch target, and selects the destination register.
- Contains an iterative 32-cycle shift-add multiplier that stalls the front end while it runs.
- Ends in the EX/MEM pipeline register, whose outputs drive the memory-access stage directly.

---
 rtl/ex_stage_if.sv | 38 +++
 rtl/ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_stage_if.sv
// Bundle between the ID/EX register and the EX stage, and from the EX/MEM register to the memory stage.
// The master side is the pipeline around EX. The slave side is ex_stage itself.
interface ex_stage_if;
    logic [31:0] i_pc_plus4;
    logic [31:0] i_read_data1;
    logic [31:0] i_read_data2;
    logic [31:0] i_imm;
    logic [4:0]  i_rt;
    logic [4:0]  i_rd;
    logic [5:0]  i_funct;
    logic [1:0]  i_WB_control;
    logic [2:0]  i_MEM_control;
    logic [3:0]  i_EX_control;
    logic        i_flush;

    logic        o_stall;
    logic [31:0] o_branch_pc;
    logic [31:0] o_result;
    logic        o_zero;
    logic [31:0] o_read_data2;
    logic [4:0]  o_write_reg;
    logic [1:0]  o_WB_control;
    logic [2:0]  o_MEM_control;

    modport master (
        output i_pc_plus4, i_read_data1, i_read_data2, i_imm, i_rt, i_rd, i_funct,
               i_WB_control, i_MEM_control, i_EX_control, i_flush,
        input  o_stall, o_branch_pc, o_result, o_zero, o_read_data2, o_write_reg,
               o_WB_control, o_MEM_control
    );

    modport slave (
        input  i_pc_plus4, i_read_data1, i_read_data2, i_imm, i_rt, i_rd, i_funct,
               i_WB_control, i_MEM_control, i_EX_control, i_flush,
        output o_stall, o_branch_pc, o_result, o_zero, o_read_data2, o_write_reg,
               o_WB_control, o_MEM_control
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, branch target, destination select, iterative shift-add multiplier, EX/MEM register.
// A mult stalls the front end from the cycle it is decoded until the product is ready.
module ex_stage #(
    parameter int MUL_CYCLES = 32
) (
    input logic       i_clk,
    input logic       i_rst_n,
    ex_stage_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    localparam logic [5:0] LastCount = 6'(MUL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
    logic [1:0]  holdWb_q, holdWb_d;
    logic [2:0]  holdMem_q, holdMem_d;
    logic [4:0]  holdWreg_q, holdWreg_d;

    logic [31:0] result_q, result_d, branch_q, branch_d, rd2_q, rd2_d;
    logic        zero_q, zero_d;
    logic [4:0]  wreg_q, wreg_d;
    logic [1:0]  wb_q, wb_d;
    logic [2:0]  mem_q, mem_d;

    logic        regDst, aluSrc, isMult, stall, startMult;
    logic [1:0]  aluOp;
    logic [31:0] opB, aluResult, branchTarget;
    logic [4:0]  writeRegSel;

    assign regDst       = bus.i_EX_control[3];
    assign aluSrc       = bus.i_EX_control[2];
    assign aluOp        = bus.i_EX_control[1:0];
    assign opB          = aluSrc ? bus.i_imm : bus.i_read_data2;
    assign writeRegSel  = regDst ? bus.i_rd : bus.i_rt;
    assign branchTarget = bus.i_pc_plus4 + {bus.i_imm[29:0], 2'b00};
    assign startMult    = (state_q == IDLE) && isMult && !bus.i_flush;

    always_comb begin
        aluResult = '0;
        isMult    = 1'b0;
        case (aluOp)
            2'b01: aluResult = bus.i_read_data1 - opB;
            2'b10: begin
                case (bus.i_funct)
                    6'h20:   aluResult = bus.i_read_data1 + opB;
                    6'h22:   aluResult = bus.i_read_data1 - opB;
                    6'h24:   aluResult = bus.i_read_data1 & opB;
                    6'h25:   aluResult = bus.i_read_data1 | opB;
                    6'h2A:   aluResult = ($signed(bus.i_read_data1) < $signed(opB)) ? 32'd1 : 32'd0;
                    6'h18:   isMult = 1'b1;
                    default: aluResult = '0;
                endcase
            end
            default: aluResult = bus.i_read_data1 + opB;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (startMult) state_d = BUSY;
            BUSY: begin
                if (bus.i_flush)             state_d = IDLE;
                else if (cnt_q == LastCount) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Anything other than a clean issue or a completed multiply leaves a bubble in EX/MEM.
    always_comb begin
        stall    = 1'b0;
        result_d = aluResult;
        zero_d   = (aluResult == '0);
        wreg_d   = writeRegSel;
        branch_d = branchTarget;
        rd2_d    = bus.i_read_data2;
        wb_d     = '0;
        mem_d    = '0;
        case (state_q)
            IDLE: begin
                if (startMult) begin
                    stall = 1'b1;
                end else if (!bus.i_flush && !isMult) begin
                    wb_d  = bus.i_WB_control;
                    mem_d = bus.i_MEM_control;
                end
            end
            BUSY: stall = 1'b1;
            DONE: begin
                if (!bus.i_flush) begin
                    result_d = prod_q;
                    zero_d   = (prod_q == '0);
                    wreg_d   = holdWreg_q;
                    wb_d     = holdWb_q;
                    mem_d    = holdMem_q;
                end
            end
            default: stall = 1'b0;
        endcase
    end

    always_comb begin
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        holdWb_d   = holdWb_q;
        holdMem_d  = holdMem_q;
        holdWreg_d = holdWreg_q;
        if (startMult) begin
            cnt_d      = '0;
            mcand_d    = bus.i_read_data1;
            mplier_d   = opB;
            prod_d     = '0;
            holdWb_d   = bus.i_WB_control;
            holdMem_d  = bus.i_MEM_control;
            holdWreg_d = writeRegSel;
        end else if (state_q == BUSY) begin
            prod_d   = prod_q + (mplier_q[0] ? mcand_q : 32'd0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 6'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            holdWb_q   <= '0;
            holdMem_q  <= '0;
            holdWreg_q <= '0;
            result_q   <= '0;
            zero_q     <= 1'b0;
            wreg_q     <= '0;
            branch_q   <= '0;
            rd2_q      <= '0;
            wb_q       <= '0;
            mem_q      <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            holdWb_q   <= holdWb_d;
            holdMem_q  <= holdMem_d;
            holdWreg_q <= holdWreg_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            wreg_q     <= wreg_d;
            branch_q   <= branch_d;
            rd2_q      <= rd2_d;
            wb_q       <= wb_d;
            mem_q      <= mem_d;
        end
    end

    // Stall is combinational, so it is gated by reset to stay low while reset is held.
    assign bus.o_stall       = stall && i_rst_n;
    assign bus.o_result      = result_q;
    assign bus.o_zero        = zero_q;
    assign bus.o_write_reg   = wreg_q;
    assign bus.o_branch_pc   = branch_q;
    assign bus.o_read_data2  = rd2_q;
    assign bus.o_WB_control  = wb_q;
    assign bus.o_MEM_control = mem_q;
endmodule

// File: tb/tb_ex_stage.sv
// Randomized and directed bench for ex_stage: the driver pushes expected EX/MEM contents into a queue.
// The monitor pops from that queue and compares each time EX/MEM holds a non-bubble.
module tb_ex_stage;
    logic clk  = 1'b0;
    logic rstN = 1'b0;

    ex_stage_if bus();

    ex_stage #(.MUL_CYCLES(32)) dut (
        .i_clk   (clk),
        .i_rst_n (rstN),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ex;
        logic [5:0]  funct;
        logic [31:0] rs, rt, imm, pc4;
        logic [4:0]  rtf, rdf;
        logic [1:0]  wb;
        logic [2:0]  mem;
        logic        flush;
    } instr_t;

    typedef struct {
        logic [31:0] result, branchPc, rd2;
        logic        zero;
        logic [4:0]  writeReg;
        logic [1:0]  wb;
        logic [2:0]  mem;
    } expect_t;

    expect_t expQ[$];
    int checks = 0;
    int errors = 0;

    function automatic instr_t mk(input logic [3:0] ex, input logic [5:0] funct,
                                  input logic [31:0] rs, input logic [31:0] rt,
                                  input logic [31:0] imm, input logic [31:0] pc4,
                                  input logic [4:0] rtf, input logic [4:0] rdf,
                                  input logic [1:0] wb, input logic [2:0] mem,
                                  input logic flush);
        instr_t in;
        in.ex = ex; in.funct = funct; in.rs = rs; in.rt = rt; in.imm = imm; in.pc4 = pc4;
        in.rtf = rtf; in.rdf = rdf; in.wb = wb; in.mem = mem; in.flush = flush;
        return in;
    endfunction

    function automatic logic isMultInstr(input instr_t in);
        return (in.ex[1:0] == 2'b10) && (in.funct == 6'h18);
    endfunction

    // Reference model works from the instruction's meaning with plain arithmetic.
    function automatic expect_t model(input instr_t in);
        expect_t e;
        logic [31:0] a, b;
        longint unsigned prod;
        longint sa, sb;
        a = in.rs;
        b = in.ex[2] ? in.imm : in.rt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        prod = {32'd0, a} * {32'd0, b};
        if (in.ex[1:0] == 2'b01) e.result = a - b;
        else if (in.ex[1:0] != 2'b10) e.result = a + b;
        else if (in.funct == 6'h20) e.result = a + b;
        else if (in.funct == 6'h22) e.result = a - b;
        else if (in.funct == 6'h24) e.result = a & b;
        else if (in.funct == 6'h25) e.result = a | b;
        else if (in.funct == 6'h2A) e.result = (sa < sb) ? 32'd1 : 32'd0;
        else if (in.funct == 6'h18) e.result = prod[31:0];
        else e.result = 32'd0;
        e.zero     = (e.result == 32'd0);
        e.writeReg = in.ex[3] ? in.rdf : in.rtf;
        e.branchPc = in.pc4 + in.imm * 32'd4;
        e.rd2      = in.rt;
        e.wb       = in.wb;
        e.mem      = in.mem;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic driveBus(input instr_t in);
        bus.i_EX_control  = in.ex;
        bus.i_funct       = in.funct;
        bus.i_read_data1  = in.rs;
        bus.i_read_data2  = in.rt;
        bus.i_imm         = in.imm;
        bus.i_pc_plus4    = in.pc4;
        bus.i_rt          = in.rtf;
        bus.i_rd          = in.rdf;
        bus.i_WB_control  = in.wb;
        bus.i_MEM_control = in.mem;
        bus.i_flush       = in.flush;
    endtask

    // Called just after a rising edge; returns just after the edge on which the instruction leaves EX.
    task automatic applyStimulus(input instr_t in);
        logic expStall;
        int n;
        driveBus(in);
        expStall = isMultInstr(in) && !in.flush;
        if (!in.flush && (in.wb != 2'b00 || in.mem != 3'b000)) expQ.push_back(model(in));
        @(negedge clk);
        checkOutput("stall", 32'(bus.o_stall), 32'(expStall));
        if (expStall) begin
            n = 1;
            for (int k = 0; k < 100; k++) begin
                @(negedge clk);
                if (bus.o_stall !== 1'b1) break;
                n++;
            end
            checkOutput("stallCycles", n, 33);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "Result"}, bus.o_result, 0);
        checkOutput({tag, "Zero"}, 32'(bus.o_zero), 0);
        checkOutput({tag, "WriteReg"}, 32'(bus.o_write_reg), 0);
        checkOutput({tag, "Wb"}, 32'(bus.o_WB_control), 0);
        checkOutput({tag, "Mem"}, 32'(bus.o_MEM_control), 0);
        checkOutput({tag, "BranchPc"}, bus.o_branch_pc, 0);
        checkOutput({tag, "ReadData2"}, bus.o_read_data2, 0);
        checkOutput({tag, "Stall"}, 32'(bus.o_stall), 0);
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (rstN && (bus.o_WB_control != 2'b00 || bus.o_MEM_control != 3'b000)) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedOutput actual=wb%0d/mem%0d expected=bubble",
                         bus.o_WB_control, bus.o_MEM_control);
            end else begin
                e = expQ.pop_front();
                checkOutput("result", bus.o_result, e.result);
                checkOutput("zero", 32'(bus.o_zero), 32'(e.zero));
                checkOutput("writeReg", 32'(bus.o_write_reg), 32'(e.writeReg));
                checkOutput("wbCtl", 32'(bus.o_WB_control), 32'(e.wb));
                checkOutput("memCtl", 32'(bus.o_MEM_control), 32'(e.mem));
                checkOutput("branchPc", bus.o_branch_pc, e.branchPc);
                checkOutput("readData2", bus.o_read_data2, e.rd2);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        instr_t nop, in;
        logic [5:0] functs [7];
        functs = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h18, 6'h3F};
        nop = mk(4'b0000, 6'h00, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1'b0);

        $display("[TB] reset with a mult on the inputs");
        driveBus(mk(4'b1010, 6'h18, $urandom, $urandom, $urandom, $urandom, 5'd9, 5'd10, 2'b11, 3'b111, 1'b0));
        rstN = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rstN = 1'b1;

        $display("[TB] directed instructions");
        applyStimulus(mk(4'b1010, 6'h20, 5, 7, 0, 32'h10, 5'd2, 5'd3, 2'b10, 3'b000, 1'b0));
        applyStimulus(mk(4'b0001, 6'h00, 9, 9, 32'hFFFFFFFF, 32'h100, 5'd9, 5'd0, 2'b00, 3'b001, 1'b0));
        applyStimulus(mk(4'b0001, 6'h00, 9, 9, 32'h1, 32'hFFFFFFFC, 5'd9, 5'd0, 2'b00, 3'b001, 1'b0));
        applyStimulus(mk(4'b1010, 6'h2A, 32'hFFFFFFFF, 1, 0, 32'h20, 5'd1, 5'd8, 2'b10, 3'b000, 1'b0));
        applyStimulus(mk(4'b0100, 6'h00, 32'h40, 32'h1234, 8, 32'h24, 5'd4, 5'd17, 2'b11, 3'b010, 1'b0));
        applyStimulus(mk(4'b1010, 6'h18, 6, 32'hFFFFFFFD, 0, 32'h28, 5'd6, 5'd12, 2'b10, 3'b000, 1'b0));
        applyStimulus(mk(4'b1010, 6'h22, 20, 5, 0, 32'h2C, 5'd5, 5'd13, 2'b10, 3'b000, 1'b0));
        applyStimulus(mk(4'b1010, 6'h18, 0, 5, 0, 32'h30, 5'd5, 5'd14, 2'b10, 3'b000, 1'b0));
        applyStimulus(mk(4'b1010, 6'h20, 1, 2, 0, 32'h34, 5'd2, 5'd15, 2'b10, 3'b000, 1'b1));
        @(negedge clk);
        checkOutput("flushIdleWb", 32'(bus.o_WB_control), 0);
        checkOutput("flushIdleMem", 32'(bus.o_MEM_control), 0);
        @(posedge clk);
        #1;

        $display("[TB] flush during multiply");
        driveBus(mk(4'b1010, 6'h18, 7, 9, 0, 32'h40, 5'd9, 5'd20, 2'b10, 3'b000, 1'b0));
        @(negedge clk);
        checkOutput("flushBusyStallOn", 32'(bus.o_stall), 1);
        repeat (10) @(posedge clk);
        #1;
        bus.i_flush = 1'b1;
        @(posedge clk);
        #1;
        driveBus(nop);
        @(negedge clk);
        checkOutput("flushBusyStall", 32'(bus.o_stall), 0);
        checkOutput("flushBusyWb", 32'(bus.o_WB_control), 0);
        checkOutput("flushBusyMem", 32'(bus.o_MEM_control), 0);
        @(posedge clk);
        #1;
        applyStimulus(mk(4'b1010, 6'h20, 100, 23, 0, 32'h44, 5'd3, 5'd21, 2'b10, 3'b000, 1'b0));

        $display("[TB] reset during multiply");
        driveBus(mk(4'b1010, 6'h18, 11, 13, 0, 32'h50, 5'd13, 5'd22, 2'b10, 3'b000, 1'b0));
        @(negedge clk);
        checkOutput("rstBusyStallOn", 32'(bus.o_stall), 1);
        repeat (20) @(posedge clk);
        #1;
        rstN = 1'b0;
        driveBus(nop);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkAllZero("rstBusy");
        @(posedge clk);
        #1;
        applyStimulus(mk(4'b1010, 6'h20, 40, 2, 0, 32'h54, 5'd2, 5'd23, 2'b01, 3'b000, 1'b0));

        $display("[TB] random instructions");
        for (int i = 0; i < 150; i++) begin
            in.ex    = 4'($urandom);
            in.funct = functs[$urandom_range(0, 6)];
            if (in.funct == 6'h18 && $urandom_range(0, 3) != 0) in.funct = 6'h20;
            if (in.funct == 6'h3F) in.funct = 6'($urandom);
            in.rs    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            in.rt    = ($urandom_range(0, 3) == 0) ? in.rs : $urandom;
            in.imm   = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
            in.pc4   = $urandom;
            in.rtf   = 5'($urandom);
            in.rdf   = 5'($urandom);
            in.wb    = 2'($urandom_range(1, 3));
            in.mem   = 3'($urandom);
            in.flush = ($urandom_range(0, 9) == 0);
            applyStimulus(in);
        end

        driveBus(nop);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("queueEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
